// File: rtl/uc_seq.sv
// Microcoded sequencer control unit: decodes opcodes into datapath strobes,
// and handles I/O handshakes with timeout, a return stack and audio playback.
module uc_seq #(
    parameter int NPORTS       = 4,
    parameter int STACK_DEPTH  = 4,
    parameter int IO_TIMEOUT   = 255,
    parameter int AUDIO_CYCLES = 16,
    localparam int PW = $clog2(NPORTS),
    localparam int SW = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic              z,
    input  logic [PW-1:0]     port_dir,
    input  logic [PW-1:0]     port_ind,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic [2:0]        op,
    output logic              s_inc,
    output logic              s_inm,
    output logic              selentrada,
    output logic              selsalida,
    output logic              s_rel,
    output logic              s_ret,
    output logic              we3,
    output logic              audioreg,
    output logic              audioact,
    output logic              pc_en,
    output logic              push_we,
    output logic [SW-1:0]     sp,
    output logic [NPORTS-1:0] enable,
    output logic              busy,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_tmo
);

    localparam int CMAX = (IO_TIMEOUT > AUDIO_CYCLES) ? IO_TIMEOUT : AUDIO_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TMO  = CW'(IO_TIMEOUT);
    localparam logic [CW-1:0] AEND = CW'(AUDIO_CYCLES - 1);
    localparam logic [SW-1:0] FULL = SW'(STACK_DEPTH);

    localparam logic [5:0] OP_JMP  = 6'b001001;
    localparam logic [5:0] OP_JZ   = 6'b001010;
    localparam logic [5:0] OP_JNZ  = 6'b001011;
    localparam logic [5:0] OP_REL  = 6'b011001;
    localparam logic [5:0] OP_ALD  = 6'b011100;
    localparam logic [5:0] OP_IN   = 6'b001100;
    localparam logic [5:0] OP_OUTA = 6'b001101;
    localparam logic [5:0] OP_OUTB = 6'b001110;
    localparam logic [5:0] OP_CALL = 6'b011010;
    localparam logic [5:0] OP_RET  = 6'b011011;
    localparam logic [5:0] OP_PLAY = 6'b011101;

    typedef enum logic [1:0] {
        EXEC,
        WAIT_IN,
        WAIT_OUT,
        AUDIO
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sp_q, sp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          tmo_q, tmo_d;

    logic          is_ind;
    logic          is_out;
    logic          out_sel;
    logic [PW-1:0] port;

    assign op      = opcode[2:0];
    assign sp      = sp_q;
    assign busy    = (state_q != EXEC);
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
    assign err_tmo = tmo_q;

    assign is_ind  = (opcode[3:0] == 4'b1111);
    assign is_out  = is_ind || (opcode == OP_OUTA) || (opcode == OP_OUTB);
    assign out_sel = (opcode != OP_OUTB);
    assign port    = is_ind ? port_ind : port_dir;

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        tmo_d      = tmo_q;
        s_inc      = 1'b1;
        pc_en      = 1'b1;
        s_inm      = 1'b0;
        selentrada = 1'b0;
        selsalida  = 1'b0;
        s_rel      = 1'b0;
        s_ret      = 1'b0;
        we3        = 1'b0;
        audioreg   = 1'b0;
        audioact   = 1'b0;
        push_we    = 1'b0;
        enable     = '0;

        unique case (state_q)
            EXEC: begin
                if (!opcode[3]) begin
                    we3 = 1'b1;
                end else if (opcode[2:0] == 3'b000) begin
                    we3   = 1'b1;
                    s_inm = 1'b1;
                end else if (is_out) begin
                    selsalida = out_sel;
                    if (out_ready) begin
                        enable[port] = 1'b1;
                    end else begin
                        pc_en   = 1'b0;
                        cnt_d   = '0;
                        state_d = WAIT_OUT;
                    end
                end else begin
                    case (opcode)
                        OP_JMP: s_inc = 1'b0;
                        OP_JZ:  s_inc = ~z;
                        OP_JNZ: s_inc = z;
                        OP_REL: s_rel = 1'b1;
                        OP_ALD: audioreg = 1'b1;
                        OP_IN: begin
                            if (in_valid) begin
                                we3        = 1'b1;
                                selentrada = 1'b1;
                            end else begin
                                pc_en   = 1'b0;
                                cnt_d   = '0;
                                state_d = WAIT_IN;
                            end
                        end
                        OP_CALL: begin
                            if (sp_q < FULL) begin
                                s_inc   = 1'b0;
                                push_we = 1'b1;
                                sp_d    = sp_q + SW'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (sp_q != '0) begin
                                s_inc = 1'b0;
                                s_ret = 1'b1;
                                sp_d  = sp_q - SW'(1);
                            end else begin
                                unf_d = 1'b1;
                            end
                        end
                        OP_PLAY: begin
                            audioact = 1'b1;
                            // single-cycle play finishes right here
                            if (AEND != '0) begin
                                pc_en   = 1'b0;
                                cnt_d   = CW'(1);
                                state_d = AUDIO;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_IN: begin
                if (in_valid) begin
                    we3        = 1'b1;
                    selentrada = 1'b1;
                    state_d    = EXEC;
                end else if (cnt_q == TMO) begin
                    tmo_d   = 1'b1;
                    state_d = EXEC;
                end else begin
                    pc_en = 1'b0;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_OUT: begin
                selsalida = out_sel;
                if (out_ready) begin
                    enable[port] = 1'b1;
                    state_d      = EXEC;
                end else if (cnt_q == TMO) begin
                    tmo_d   = 1'b1;
                    state_d = EXEC;
                end else begin
                    pc_en = 1'b0;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            AUDIO: begin
                audioact = 1'b1;
                if (cnt_q == AEND) begin
                    state_d = EXEC;
                end else begin
                    pc_en = 1'b0;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = EXEC;
        endcase

        // reset kills any pending strobe at once, not on the next edge
        if (reset) begin
            pc_en      = 1'b0;
            s_inc      = 1'b1;
            s_inm      = 1'b0;
            selentrada = 1'b0;
            selsalida  = 1'b0;
            s_rel      = 1'b0;
            s_ret      = 1'b0;
            we3        = 1'b0;
            audioreg   = 1'b0;
            audioact   = 1'b0;
            push_we    = 1'b0;
            enable     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EXEC;
            sp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_uc_seq.sv
// Bench for uc_seq: directed and random instructions checked against a
// per-instruction model of stall length, strobes, stack depth and error flags.
module tb_uc_seq;

    localparam int NP = 4;
    localparam int SD = 4;
    localparam int TO = 4;
    localparam int AC = 3;
    localparam int PW = 2;
    localparam int SW = 3;

    localparam int K_ALU  = 0;
    localparam int K_LOAD = 1;
    localparam int K_JMP  = 2;
    localparam int K_JZ   = 3;
    localparam int K_JNZ  = 4;
    localparam int K_REL  = 5;
    localparam int K_ALD  = 6;
    localparam int K_IN   = 7;
    localparam int K_OUT  = 8;
    localparam int K_CALL = 9;
    localparam int K_RET  = 10;
    localparam int K_PLAY = 11;
    localparam int K_NOP  = 12;

    localparam logic [5:0] NOP  = 6'b101001;
    localparam logic [5:0] CALL = 6'b011010;
    localparam logic [5:0] RET  = 6'b011011;
    localparam logic [5:0] PLAY = 6'b011101;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic          z;
    logic [PW-1:0] port_dir, port_ind;
    logic          in_valid, out_ready;
    logic [2:0]    op;
    logic          s_inc, s_inm, selentrada, selsalida, s_rel, s_ret;
    logic          we3, audioreg, audioact, pc_en, push_we;
    logic [SW-1:0] sp;
    logic [NP-1:0] enable;
    logic          busy, err_ovf, err_unf, err_tmo;

    int n_chk = 0;
    int n_fail = 0;
    int m_sp = 0;
    bit m_ovf = 0, m_unf = 0, m_tmo = 0;

    logic [5:0] specials [0:11] = '{
        6'b001001, 6'b001010, 6'b001011, 6'b011001,
        6'b011100, 6'b001100, 6'b001101, 6'b001110,
        6'b101111, 6'b011101, 6'b111000, 6'b000101
    };

    always #5 clk = ~clk;

    uc_seq #(
        .NPORTS(NP), .STACK_DEPTH(SD),
        .IO_TIMEOUT(TO), .AUDIO_CYCLES(AC)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z),
        .port_dir(port_dir), .port_ind(port_ind),
        .in_valid(in_valid), .out_ready(out_ready),
        .op(op), .s_inc(s_inc), .s_inm(s_inm),
        .selentrada(selentrada), .selsalida(selsalida),
        .s_rel(s_rel), .s_ret(s_ret), .we3(we3),
        .audioreg(audioreg), .audioact(audioact),
        .pc_en(pc_en), .push_we(push_we), .sp(sp),
        .enable(enable), .busy(busy),
        .err_ovf(err_ovf), .err_unf(err_unf), .err_tmo(err_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int kind_of(input logic [5:0] o);
        if (!o[3]) return K_ALU;
        if (o[2:0] == 3'b000) return K_LOAD;
        if (o[3:0] == 4'b1111) return K_OUT;
        case (o)
            6'b001001: return K_JMP;
            6'b001010: return K_JZ;
            6'b001011: return K_JNZ;
            6'b011001: return K_REL;
            6'b011100: return K_ALD;
            6'b001100: return K_IN;
            6'b001101: return K_OUT;
            6'b001110: return K_OUT;
            6'b011010: return K_CALL;
            6'b011011: return K_RET;
            6'b011101: return K_PLAY;
            default:   return K_NOP;
        endcase
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".sp"}, sp, m_sp);
        chk({tag, ".ovf"}, err_ovf, m_ovf);
        chk({tag, ".unf"}, err_unf, m_unf);
        chk({tag, ".tmo"}, err_tmo, m_tmo);
        chk({tag, ".busy"}, busy, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".pc_en"}, pc_en, 0);
        chk({tag, ".s_inc"}, s_inc, 1);
        chk({tag, ".we3"}, we3, 0);
        chk({tag, ".push_we"}, push_we, 0);
        chk({tag, ".enable"}, enable, 0);
        chk({tag, ".audioact"}, audioact, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".sp"}, sp, 0);
        chk({tag, ".errs"}, {err_ovf, err_unf, err_tmo}, 0);
    endtask

    task automatic model_clear();
        m_sp = 0;
        m_ovf = 0;
        m_unf = 0;
        m_tmo = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        opcode = NOP;
        in_valid = 0;
        out_ready = 0;
        reset = 1;
        #1;
        check_reset_outs("rst");
        @(negedge clk);
        reset = 0;
        model_clear();
    endtask

    // Drive one instruction; in_valid/out_ready rise after dly cycles.
    task automatic run(input logic [5:0] o, input int dly, input logic zz,
                       input logic [PW-1:0] pd, input logic [PW-1:0] pi);
        int kd, last, port, exp_inc;
        bit hs, push, pop, io;
        logic [NP-1:0] en_x;
        kd = kind_of(o);
        io = (kd == K_IN) || (kd == K_OUT);
        last = 0;
        hs = 1;
        if (io) begin
            if (dly <= TO + 1) last = dly;
            else begin
                last = TO + 1;
                hs = 0;
            end
        end else if (kd == K_PLAY) begin
            last = AC - 1;
        end
        push = (kd == K_CALL) && (m_sp < SD);
        pop = (kd == K_RET) && (m_sp > 0);
        port = (o[3:0] == 4'hF) ? int'(pi) : int'(pd);
        case (kd)
            K_JMP:   exp_inc = 0;
            K_JZ:    exp_inc = int'(~zz);
            K_JNZ:   exp_inc = int'(zz);
            K_CALL:  exp_inc = int'(!push);
            K_RET:   exp_inc = int'(!pop);
            default: exp_inc = 1;
        endcase
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            opcode = o;
            z = zz;
            port_dir = pd;
            port_ind = pi;
            in_valid = (k >= dly);
            out_ready = (k >= dly);
            #1;
            en_x = '0;
            if (kd == K_OUT && k == last && hs) en_x[port] = 1'b1;
            chk("op", op, o[2:0]);
            chk("pc_en", pc_en, k == last);
            chk("busy", busy, k > 0);
            chk("we3", we3, (k == 0 && (kd == K_ALU || kd == K_LOAD))
                || (kd == K_IN && k == last && hs));
            chk("s_inc", s_inc, exp_inc);
            chk("s_inm", s_inm, kd == K_LOAD);
            chk("selentrada", selentrada, kd == K_IN && k == last && hs);
            chk("selsalida", selsalida, kd == K_OUT && o != 6'b001110);
            chk("s_rel", s_rel, kd == K_REL);
            chk("s_ret", s_ret, pop);
            chk("push_we", push_we, push);
            chk("audioreg", audioreg, kd == K_ALD);
            chk("audioact", audioact, kd == K_PLAY);
            chk("enable", enable, en_x);
        end
        if (push) m_sp++;
        if (pop) m_sp--;
        if (kd == K_CALL && !push) m_ovf = 1;
        if (kd == K_RET && !pop) m_unf = 1;
        if (io && !hs) m_tmo = 1;
        @(negedge clk);
        opcode = NOP;
        in_valid = 0;
        out_ready = 0;
        #1;
        check_state("post");
    endtask

    initial begin
        reset = 1;
        opcode = CALL;
        z = 0;
        port_dir = 0;
        port_ind = 0;
        in_valid = 0;
        out_ready = 0;

        // reset overrides a presented call; first edge after release runs it
        @(negedge clk);
        #1;
        check_reset_outs("init");
        chk("init.op", op, 3'b010);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        opcode = NOP;
        #1;
        m_sp = 1;
        chk("first_edge.sp", sp, 1);

        do_reset();
        run(6'b001100, 3, 0, 0, 0);
        run(6'b001111, 0, 0, 0, 2);
        for (int i = 0; i < 5; i++) run(CALL, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) run(RET, 0, 0, 0, 0);
        run(6'b001101, 100, 0, 1, 0);
        run(PLAY, 0, 0, 0, 0);

        // abort a play mid-way
        @(negedge clk);
        opcode = PLAY;
        #1;
        chk("ply0.act", audioact, 1);
        chk("ply0.pc_en", pc_en, 0);
        @(negedge clk);
        #1;
        chk("ply1.act", audioact, 1);
        chk("ply1.busy", busy, 1);
        reset = 1;
        #1;
        chk("plyrst.act", audioact, 0);
        chk("plyrst.pc_en", pc_en, 0);
        chk("plyrst.s_inc", s_inc, 1);
        chk("plyrst.busy", busy, 0);
        opcode = NOP;
        @(negedge clk);
        reset = 0;
        model_clear();

        // abort an output wait as the device becomes ready
        @(negedge clk);
        opcode = 6'b001101;
        port_dir = 1;
        #1;
        chk("wo0.pc_en", pc_en, 0);
        chk("wo0.enable", enable, 0);
        @(negedge clk);
        #1;
        chk("wo1.busy", busy, 1);
        reset = 1;
        out_ready = 1;
        #1;
        chk("worst.enable", enable, 0);
        chk("worst.busy", busy, 0);
        opcode = NOP;
        @(negedge clk);
        reset = 0;
        out_ready = 0;
        model_clear();

        for (int i = 0; i < 80; i++) begin
            logic [5:0] o;
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: o = 6'($urandom_range(0, 63));
                1: o = specials[$urandom_range(0, 11)];
                2: o = CALL;
                default: o = RET;
            endcase
            run(o, $urandom_range(0, TO + 2), 1'($urandom_range(0, 1)),
                PW'($urandom_range(0, NP - 1)), PW'($urandom_range(0, NP - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uc_seq.md
UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 Parameter NPORTS, default 4, number of output ports (power of 2, >=2); PW = clog2(NPORTS).
REQ-002 Parameter STACK_DEPTH, default 4, return-address stack entries (power of 2, >=2); SW = clog2(STACK_DEPTH)+1.
REQ-003 Parameter IO_TIMEOUT, default 255, maximum wait cycles for an I/O handshake (>=1).
REQ-004 Parameter AUDIO_CYCLES, default 16, cycles audioact stays high per play instruction (>=1).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 opcode  in  6  current instruction opcode; z  in  1  ALU zero flag.
REQ-008 port_dir  in  PW  port index for direct outputs; port_ind  in  PW  port index for indirect outputs.
REQ-009 in_valid  in  1  input device has data; out_ready  in  1  addressed output device accepts data.
REQ-010 op  out  3  ALU operation, equal to opcode[2:0] at all times.
REQ-011 s_inc, s_inm, selentrada, selsalida, s_rel, s_ret, we3, audioreg, audioact  out  1 each  datapath controls.
REQ-012 pc_en  out  1  PC register load enable; push_we  out  1  write return address at stack index sp.
REQ-013 sp  out  SW  stack pointer (entries in use); ret index is sp-1.
REQ-014 enable  out  NPORTS  one-hot output-port strobe.
REQ-015 busy  out  1  high whenever state != EXEC; err_ovf, err_unf, err_tmo  out  1 each  sticky error flags.

Function
REQ-016 Registered state SHALL be: FSM state {EXEC, WAIT_IN, WAIT_OUT, AUDIO}, sp, wait/audio counter, three error flags; all control outputs SHALL be combinational from state, opcode, z, in_valid, out_ready, sp.
REQ-017 Default in every state/opcode unless stated: s_inc=1, pc_en=1, every other control, enable and push_we = 0.
REQ-018 EXEC decode (x = don't care): xx0xxx ALU: we3=1; xx1000 load: we3=1, s_inm=1; 001001 jump: s_inc=0; 001010 jz: s_inc=~z; 001011 jnz: s_inc=z; 011001 relative: s_rel=1.
REQ-019 011100 audio load: audioreg=1 for one cycle; all unlisted opcodes SHALL be NOP (defaults only).
REQ-020 001100 input: if in_valid=1 then we3=1, selentrada=1, complete in one cycle; else pc_en=0, we3=0, counter<=0, go WAIT_IN.
REQ-021 WAIT_IN: pc_en=0 until in_valid=1, then we3=1, selentrada=1, pc_en=1, go EXEC; counter increments each waiting cycle.
REQ-022 Outputs 001101 (selsalida=1, port_dir), 001110 (selsalida=0, port_dir), xx1111 (selsalida=1, port_ind): enable[port]=1 and pc_en=1 only in the cycle out_ready=1; else pc_en=0, go/stay WAIT_OUT.
REQ-023 In WAIT_OUT, selsalida and port selection SHALL follow the held opcode; opcode SHALL be stable while busy=1.
REQ-024 Timeout: if counter reaches IO_TIMEOUT in WAIT_IN/WAIT_OUT without handshake, that cycle SHALL assert pc_en=1, no we3/enable, set err_tmo, go EXEC.
REQ-025 011010 call: if sp<STACK_DEPTH then s_inc=0, push_we=1, sp<=sp+1; if full, NOP and set err_ovf.
REQ-026 011011 return: if sp>0 then s_inc=0, s_ret=1, sp<=sp-1; if empty, NOP and set err_unf.
REQ-027 011101 play: audioact=1 for exactly AUDIO_CYCLES consecutive cycles (EXEC plus AUDIO), pc_en=0 on all but the last, pc_en=1 on the last, then EXEC.
REQ-028 Error flags SHALL remain set until reset; errors SHALL NOT halt execution.

Reset
REQ-029 While reset=1, asynchronously: state=EXEC, sp=0, counter=0, err_*=0, pc_en=0, s_inc=1, all other outputs 0 except op.
REQ-030 Reset asserted mid-WAIT or mid-AUDIO SHALL abort without a late enable, we3 or push_we pulse.
REQ-031 First edge after reset release SHALL execute the presented opcode from EXEC.

Verification
REQ-032 opcode=001100, in_valid low 3 cycles then high -> pc_en=0 x3, 4th cycle we3=1, selentrada=1, pc_en=1.
REQ-033 opcode=xx1111, port_ind=2, out_ready=1 -> enable=0100, selsalida=1, pc_en=1 same cycle.
REQ-034 STACK_DEPTH=4: 5 calls -> sp 1,2,3,4,4, push_we low on 5th, err_ovf=1; 5 returns -> sp 3..0, 5th sets err_unf.
REQ-035 IO_TIMEOUT=4, opcode=001101, out_ready=0 -> timeout cycle pc_en=1, enable=0, err_tmo=1, busy=0 next.
REQ-036 AUDIO_CYCLES=3, opcode=011101 -> audioact=1 for 3 cycles, pc_en=0,0,1; reset in cycle 2 -> audioact=0 immediately.
